// File: rtl/mcp3008_pkg.sv
// rtl/mcp3008_pkg.sv - shared types and frame timing constants for the MCP3008 responder
package mcp3008_pkg;

  typedef enum logic [2:0] {IDLE, CMD, SAMPLE, DATA, TAIL} state_t;

  localparam int N_DEFAULT        = 10;
  localparam int CHANNELS_DEFAULT = 8;
  localparam int CHAN_N_DEFAULT   = 3;

  // Command word layout {SGL, D2, D1, D0}
  localparam int SGL_BIT = 3;
  localparam int D2_BIT  = 2;
  localparam int D1_BIT  = 1;
  localparam int D0_BIT  = 0;

  // Bit-counter values, counted in rising edges after the start bit
  localparam logic [4:0] CMD_BITS  = 5'd4;
  localparam logic [4:0] NULL_IDX  = 5'd5;
  localparam logic [4:0] DATA_LAST = 5'd15;
  localparam logic [4:0] LSBF_LAST = 5'd24;
  localparam logic [4:0] CNT_MAX   = 5'd31;

endpackage

// File: rtl/mcp3008_input_sel.sv
// rtl/mcp3008_input_sel.sv - command to conversion result: single-ended mux, clamped differential, range check
module mcp3008_input_sel
  import mcp3008_pkg::*;
#(
  parameter int N        = N_DEFAULT,
  parameter int CHANNELS = CHANNELS_DEFAULT,
  parameter int CHAN_N   = CHAN_N_DEFAULT
) (
  input  logic [3:0]            cmd,
  input  logic [CHANNELS*N-1:0] chan_data,
  output logic [N-1:0]          result
);

  localparam int SLOTS = 1 << CHAN_N;

  logic [N-1:0]      slot [SLOTS];
  logic [SLOTS-1:0]  slot_valid;
  logic [CHAN_N-1:0] pos_idx;
  logic [CHAN_N-1:0] neg_idx;
  logic [N-1:0]      pos_val;
  logic [N-1:0]      neg_val;

  // Addressable slots beyond CHANNELS read as absent so they force a zero result
  genvar g;
  generate
    for (g = 0; g < SLOTS; g++) begin : g_slot
      if (g < CHANNELS) begin : g_real
        assign slot[g]       = chan_data[g*N +: N];
        assign slot_valid[g] = 1'b1;
      end else begin : g_absent
        assign slot[g]       = '0;
        assign slot_valid[g] = 1'b0;
      end
    end
  endgenerate

  // IN- is the pair partner (D0 inverted); a negative difference clamps to zero
  always_comb begin
    pos_idx = {cmd[D2_BIT], cmd[D1_BIT], cmd[D0_BIT]};
    neg_idx = {cmd[D2_BIT], cmd[D1_BIT], ~cmd[D0_BIT]};
    pos_val = slot[pos_idx];
    neg_val = slot[neg_idx];
    result  = '0;
    if (cmd[SGL_BIT]) begin
      if (slot_valid[pos_idx]) result = pos_val;
    end else if (slot_valid[pos_idx] && slot_valid[neg_idx] && (pos_val > neg_val)) begin
      result = pos_val - neg_val;
    end
  end

endmodule

// File: rtl/mcp3008_responder.sv
// rtl/mcp3008_responder.sv - MCP3008 device-side SPI model; MCP3008_LSBF_EN adds the LSB-first tail repeat
module mcp3008_responder
  import mcp3008_pkg::*;
#(
  parameter int N        = N_DEFAULT,
  parameter int CHANNELS = CHANNELS_DEFAULT,
  parameter int CHAN_N   = CHAN_N_DEFAULT
) (
  input  logic                  reset_n,
  input  logic                  SCLK,
  input  logic                  CS_n,
  input  logic                  din,
  input  logic [CHANNELS*N-1:0] chan_data,
  output logic                  dout,
  output logic                  dout_oe,
  output logic                  sample_stb,
  output logic [N-1:0]          sample_code,
  output logic [3:0]            sample_cmd
);

  state_t       state;
  logic [4:0]   bit_cnt;
  logic [3:0]   cmd;
  logic [N-1:0] result;
  logic [N-1:0] shift_reg;

  mcp3008_input_sel #(
    .N        (N),
    .CHANNELS (CHANNELS),
    .CHAN_N   (CHAN_N)
  ) u_input_sel (
    .cmd       (cmd),
    .chan_data (chan_data),
    .result    (result)
  );

  // Rising edge: frame sequencing, command capture and the sample report pulse
  always_ff @(posedge SCLK or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      cmd         <= '0;
      sample_stb  <= 1'b0;
      sample_code <= '0;
      sample_cmd  <= '0;
    end else if (CS_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      sample_stb <= 1'b0;
    end else begin
      sample_stb <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (din) state <= CMD;
        end
        CMD: begin
          cmd     <= {cmd[2:0], din};
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == CMD_BITS - 5'd1) state <= SAMPLE;
        end
        SAMPLE: begin
          bit_cnt <= bit_cnt + 5'd1;
          state   <= DATA;
        end
        DATA: begin
          bit_cnt <= bit_cnt + 5'd1;
          // shift_reg was loaded on the preceding falling edge
          if (bit_cnt == NULL_IDX) begin
            sample_stb  <= 1'b1;
            sample_code <= shift_reg;
            sample_cmd  <= cmd;
          end
          if (bit_cnt == DATA_LAST) state <= TAIL;
        end
        TAIL: begin
          if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 5'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Falling edge: latch the result, then rotate it out MSB-first (and back LSB-first in the tail)
  always_ff @(negedge SCLK or negedge reset_n) begin
    if (!reset_n) begin
      dout      <= 1'b0;
      dout_oe   <= 1'b0;
      shift_reg <= '0;
    end else begin
      case (state)
        DATA: begin
          if (bit_cnt == NULL_IDX) begin
            shift_reg <= result;
            dout_oe   <= 1'b1;
            dout      <= 1'b0;
          end else begin
            // Rotating keeps the full word so the tail can replay it
            dout      <= shift_reg[N-1];
            shift_reg <= {shift_reg[N-2:0], shift_reg[N-1]};
          end
        end
        TAIL: begin
`ifdef MCP3008_LSBF_EN
          if (bit_cnt <= LSBF_LAST) begin
            dout      <= shift_reg[1];
            shift_reg <= {shift_reg[0], shift_reg[N-1:1]};
          end else begin
            dout <= 1'b0;
          end
`else
          dout <= 1'b0;
`endif
        end
        default: begin
          dout    <= 1'b0;
          dout_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule
